// File: rtl/cp1_gsel_ctrl.sv
// cp1_gsel_ctrl: clocked front-end of the PROG CPLD address mapper.
// Synchronises the 68K low-byte write strobe, decodes P-bank writes and
// guards game-select changes behind a two-key unlock plus a settle window.
module cp1_gsel_ctrl #(
   parameter logic [18:0] GSEL_ADDR      = 19'h607F7,
   parameter logic [7:0]  KEY1           = 8'h5A,
   parameter logic [7:0]  KEY2           = 8'hA5,
   parameter int          UNLOCK_TIMEOUT = 1024,
   parameter int          SETTLE_CYCLES  = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [18:0] M68K_ADDR,
   input  logic [15:0] M68K_DATA,
   input  logic        nPORTWEL,
   input  logic [2:0]  BANKS_MAX,
   output logic [2:0]  P_BANK,
   output logic [7:0]  GSEL,
   output logic        GSEL_BUSY,
   output logic        BANK_WE,
   output logic [1:0]  UNLOCK_ST
);

   // Counter widths; a parameter of 1 would give a zero-width vector.
   localparam int TO_W = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
   localparam int ST_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(UNLOCK_TIMEOUT - 1);
   localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KEY1  = 2'd1,
      ST_ARMED = 2'd2
   } unlock_t;

   logic [2:0]      r_we_s;
   logic [18:0]     r_cap_addr;
   logic [7:0]      r_cap_data;
   logic            r_ev;
   unlock_t         r_state;
   logic [TO_W-1:0] r_to_cnt;
   logic [ST_W-1:0] r_settle;
   logic            r_busy;
   logic [2:0]      r_p_bank;
   logic [7:0]      r_gsel;
   logic            r_bank_we;

   logic            w_is_gsel;
   logic [2:0]      w_bank;
   logic            w_unused_data;

   // Only the low data byte is wired to this port.
   assign w_unused_data = ^M68K_DATA[15:8];

   // Strobe synchroniser; idles high so reset never fakes a rising edge.
   always_ff @(posedge CLK) begin
      if (RESET) r_we_s <= 3'b111;
      else       r_we_s <= {r_we_s[1:0], nPORTWEL};
   end

   // Track the bus while the synchronised strobe is low; freeze once it rises.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cap_addr <= '0;
         r_cap_data <= '0;
      end else if (!r_we_s[1]) begin
         r_cap_addr <= M68K_ADDR;
         r_cap_data <= M68K_DATA[7:0];
      end
   end

   // Rising-edge detect, registered so the frozen capture and BANKS_MAX are
   // used one cycle later; outputs land on the 4th edge after the strobe rises.
   always_ff @(posedge CLK) begin
      if (RESET) r_ev <= 1'b0;
      else       r_ev <= r_we_s[1] & ~r_we_s[2];
   end

   assign w_is_gsel = (r_cap_addr == GSEL_ADDR);
   assign w_bank    = (r_cap_data[2:0] <= BANKS_MAX) ? r_cap_data[2:0] : 3'd0;

   // Unlock FSM, timeout, settle window and the bank/GSEL registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_to_cnt  <= '0;
         r_settle  <= '0;
         r_busy    <= 1'b0;
         r_p_bank  <= 3'd0;
         r_gsel    <= 8'd0;
         r_bank_we <= 1'b0;
      end else begin
         r_bank_we <= 1'b0;

         // Settle countdown: busy drops on the edge after the count hits 0.
         if (r_busy) begin
            if (r_settle == '0) r_busy   <= 1'b0;
            else                r_settle <= r_settle - 1'b1;
         end

         // Timeout only runs mid-sequence; any event restarts it and wins a tie.
         if (r_state == ST_IDLE || r_ev) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt <= '0;
            r_state  <= ST_IDLE;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         // While busy every event is dropped; the FSM is IDLE then anyway.
         if (r_ev && !r_busy) begin
            if (w_is_gsel) begin
               case (r_state)
                  ST_IDLE:  r_state <= (r_cap_data == KEY1) ? ST_KEY1 : ST_IDLE;
                  ST_KEY1: begin
                     if (r_cap_data == KEY2)      r_state <= ST_ARMED;
                     else if (r_cap_data == KEY1) r_state <= ST_KEY1;
                     else                         r_state <= ST_IDLE;
                  end
                  ST_ARMED: begin
                     r_gsel   <= r_cap_data;
                     r_p_bank <= 3'd0;
                     r_busy   <= 1'b1;
                     r_settle <= ST_LOAD;
                     r_state  <= ST_IDLE;
                  end
                  default:  r_state <= ST_IDLE;
               endcase
            end else begin
               r_p_bank  <= w_bank;
               r_bank_we <= 1'b1;
            end
         end
      end
   end

   assign P_BANK    = r_p_bank;
   assign GSEL      = r_gsel;
   assign GSEL_BUSY = r_busy;
   assign BANK_WE   = r_bank_we;
   assign UNLOCK_ST = r_state;

endmodule

// File: tb/tb_cp1_gsel_ctrl.sv
// tb_cp1_gsel_ctrl: directed scenarios plus randomized writes, compared every
// cycle against a transaction-level model of the mapper front-end.
module tb_cp1_gsel_ctrl;

   localparam logic [18:0] GA   = 19'h607F7;
   localparam int          K1   = 8'h5A;
   localparam int          K2   = 8'hA5;
   localparam int          TOUT = 1024;
   localparam int          SETL = 16;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [18:0] M68K_ADDR = '0;
   logic [15:0] M68K_DATA = '0;
   logic        nPORTWEL = 1'b1;
   logic [2:0]  BANKS_MAX = 3'd7;
   logic [2:0]  P_BANK;
   logic [7:0]  GSEL;
   logic        GSEL_BUSY;
   logic        BANK_WE;
   logic [1:0]  UNLOCK_ST;

   cp1_gsel_ctrl dut (
      .CLK(CLK), .RESET(RESET), .M68K_ADDR(M68K_ADDR), .M68K_DATA(M68K_DATA),
      .nPORTWEL(nPORTWEL), .BANKS_MAX(BANKS_MAX), .P_BANK(P_BANK), .GSEL(GSEL),
      .GSEL_BUSY(GSEL_BUSY), .BANK_WE(BANK_WE), .UNLOCK_ST(UNLOCK_ST)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int at; logic [18:0] a; logic [7:0] d; } ev_t;
   ev_t q[$];
   int  cyc = 0;
   int  m_state = 0, m_gsel = 0, m_pbank = 0, m_we = 0, m_busy_left = 0, m_idle = 0;
   bit  m_ev, m_busy;
   ev_t m_e;
   int  m_b;

   // Each write becomes an event scheduled at an absolute edge number.
   always @(posedge CLK) begin
      cyc++;
      if (RESET) begin
         m_state = 0; m_gsel = 0; m_pbank = 0; m_we = 0; m_busy_left = 0; m_idle = 0;
         q.delete();
      end else begin
         m_ev = 0;
         if (q.size() > 0 && q[0].at == cyc) begin
            m_ev = 1;
            m_e  = q.pop_front();
         end
         m_busy = (m_busy_left > 0);
         m_we   = 0;
         if (m_busy_left > 0) m_busy_left--;
         if (m_ev) begin
            m_idle = 0;
            if (!m_busy) begin
               if (m_e.a != GA) begin
                  m_b     = int'(m_e.d) % 8;
                  m_pbank = (m_b <= int'(BANKS_MAX)) ? m_b : 0;
                  m_we    = 1;
               end else if (m_state == 0) begin
                  m_state = (int'(m_e.d) == K1) ? 1 : 0;
               end else if (m_state == 1) begin
                  m_state = (int'(m_e.d) == K2) ? 2 : (int'(m_e.d) == K1) ? 1 : 0;
               end else begin
                  m_gsel = int'(m_e.d); m_pbank = 0; m_busy_left = SETL; m_state = 0;
               end
            end
         end else if (m_state != 0) begin
            m_idle++;
            if (m_idle >= TOUT) begin m_state = 0; m_idle = 0; end
         end else begin
            m_idle = 0;
         end
      end
   end

   // ---------------- per-cycle monitor ----------------
   bit mon_en = 0;
   int we_cnt = 0, busy_run = 0, last_busy_run = 0;

   always @(negedge CLK) begin
      if (mon_en) begin
         chk("m_pbank", P_BANK, m_pbank);
         chk("m_gsel",  GSEL,   m_gsel);
         chk("m_busy",  GSEL_BUSY, (m_busy_left > 0) ? 1 : 0);
         chk("m_we",    BANK_WE, m_we);
         chk("m_state", UNLOCK_ST, m_state);
         if (BANK_WE) we_cnt++;
         if (GSEL_BUSY) busy_run++;
         else if (busy_run > 0) begin last_busy_run = busy_run; busy_run = 0; end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic pulse_reset();
      RESET = 1'b1; wait_cyc(1); RESET = 1'b0;
   endtask

   // Hold the strobe low until edge rise_at, then release it and log the event.
   task automatic strobe_at(input logic [18:0] a, input logic [7:0] d, input int rise_at,
                            output int apply);
      M68K_ADDR = a;
      M68K_DATA = {8'($urandom_range(0, 255)), d};
      nPORTWEL  = 1'b0;
      while (cyc < rise_at) begin @(posedge CLK); #1; end
      nPORTWEL = 1'b1;
      apply = cyc + 4;
      q.push_back('{apply, a, d});
      wait_cyc(3);
      M68K_ADDR = 19'($urandom);
      M68K_DATA = 16'($urandom);
      wait_cyc(2);
   endtask

   task automatic strobe(input logic [18:0] a, input logic [7:0] d, input int low);
      int ap;
      strobe_at(a, d, cyc + low, ap);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   int ap, w0, e0;
   int k, kd, nwr;
   logic [18:0] ra;
   logic [7:0]  rd;

   initial begin
      wait_cyc(2);
      RESET = 1'b0;
      mon_en = 1;
      @(negedge CLK);
      chk("rst_pbank", P_BANK, 0);
      chk("rst_gsel", GSEL, 0);
      chk("rst_busy", GSEL_BUSY, 0);
      chk("rst_we", BANK_WE, 0);
      chk("rst_st", UNLOCK_ST, 0);
      wait_cyc(1);

      // Bank write latency: result on the 4th edge after the strobe rises.
      BANKS_MAX = 3'd5;
      M68K_ADDR = 19'd0; M68K_DATA = 16'h0003; nPORTWEL = 1'b0;
      wait_cyc(3);
      w0 = we_cnt;
      nPORTWEL = 1'b1;
      q.push_back('{cyc + 4, 19'd0, 8'h03});
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("lat_pre_pbank", P_BANK, 0);
      chk("lat_pre_we", BANK_WE, 0);
      @(negedge CLK);
      chk("lat_pbank", P_BANK, 3);
      chk("lat_we", BANK_WE, 1);
      @(negedge CLK);
      chk("we_one_cycle", BANK_WE, 0);
      #1; wait_cyc(2);
      chk("we_count1", we_cnt - w0, 1);

      // Out-of-range bank clears to 0 but still pulses.
      w0 = we_cnt;
      strobe(19'd0, 8'h06, 3);
      chk("oob_pbank", P_BANK, 0);
      chk("oob_we", we_cnt - w0, 1);

      // Game switch with a bank write dropped inside the settle window.
      strobe(GA, 8'h5A, 2);
      chk("sw_st1", UNLOCK_ST, 1);
      strobe(GA, 8'hA5, 2);
      chk("sw_st2", UNLOCK_ST, 2);
      strobe(GA, 8'h12, 2);
      chk("sw_st0", UNLOCK_ST, 0);
      chk("sw_gsel", GSEL, 8'h12);
      chk("sw_pbank", P_BANK, 0);
      chk("sw_busy", GSEL_BUSY, 1);
      w0 = we_cnt;
      strobe(19'd0, 8'h01, 2);
      wait_cyc(14);
      chk("busy_len", last_busy_run, SETL);
      chk("busy_drop_pbank", P_BANK, 0);
      chk("busy_drop_we", we_cnt - w0, 0);

      // Broken sequence aborts; a repeated KEY1 is tolerated.
      strobe(GA, 8'h5A, 2);
      strobe(GA, 8'h33, 2);
      chk("bad_st", UNLOCK_ST, 0);
      strobe(GA, 8'h12, 2);
      chk("bad_gsel", GSEL, 8'h12);
      strobe(GA, 8'h5A, 2);
      strobe(GA, 8'h5A, 2);
      chk("k1k1_st", UNLOCK_ST, 1);
      strobe(GA, 8'hA5, 2);
      strobe(GA, 8'h07, 2);
      chk("k1k1_gsel", GSEL, 8'h07);
      wait_cyc(20);

      // Timeout: KEY1 then silence aborts on edge E+1024.
      strobe_at(GA, 8'h5A, cyc + 2, e0);
      while (cyc < e0 + TOUT - 1) begin @(posedge CLK); #1; end
      @(negedge CLK);
      chk("to_before", UNLOCK_ST, 1);
      @(negedge CLK);
      chk("to_abort", UNLOCK_ST, 0);
      #1;
      strobe(GA, 8'hA5, 2);
      strobe(GA, 8'h20, 2);
      chk("to_gsel", GSEL, 8'h07);
      chk("to_st", UNLOCK_ST, 0);

      // KEY2 landing exactly on the terminal cycle still arms.
      strobe_at(GA, 8'h5A, cyc + 2, e0);
      strobe_at(GA, 8'hA5, e0 + TOUT - 4, ap);
      chk("term_apply", ap, e0 + TOUT);
      chk("term_armed", UNLOCK_ST, 2);
      strobe(GA, 8'h20, 2);
      chk("term_gsel", GSEL, 8'h20);

      // Reset mid-settle, then reset while ARMED.
      wait_cyc(3);
      pulse_reset();
      @(negedge CLK);
      chk("rs_gsel", GSEL, 0);
      chk("rs_busy", GSEL_BUSY, 0);
      chk("rs_pbank", P_BANK, 0);
      #1;
      strobe(GA, 8'h5A, 2);
      strobe(GA, 8'hA5, 2);
      chk("rs_armed", UNLOCK_ST, 2);
      pulse_reset();
      @(negedge CLK);
      chk("ra_st", UNLOCK_ST, 0);
      #1;
      strobe(GA, 8'h44, 2);
      chk("ra_gsel", GSEL, 0);
      chk("ra_st2", UNLOCK_ST, 0);

      // Strobe already low across reset release is still taken.
      BANKS_MAX = 3'd7;
      M68K_ADDR = 19'd0; M68K_DATA = 16'h0002; nPORTWEL = 1'b0;
      wait_cyc(2);
      pulse_reset();
      wait_cyc(3);
      nPORTWEL = 1'b1;
      q.push_back('{cyc + 4, 19'd0, 8'h02});
      wait_cyc(6);
      chk("rst_low_pbank", P_BANK, 2);

      // Randomized traffic against the model.
      nwr = 0;
      for (int i = 0; i < 300; i++) begin
         BANKS_MAX = 3'($urandom_range(0, 7));
         k  = $urandom_range(0, 9);
         kd = $urandom_range(0, 3);
         ra = (k < 4) ? 19'($urandom) : GA;
         rd = (kd == 0) ? 8'h5A : (kd == 1) ? 8'hA5 : 8'($urandom_range(0, 255));
         strobe(ra, rd, $urandom_range(2, 4));
         nwr++;
         if ($urandom_range(0, 7) == 0) wait_cyc($urandom_range(1, 30));
         if ($urandom_range(0, 49) == 0) wait_cyc(TOUT + 5);
      end
      wait_cyc(20);
      chk("rand_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
